reg_cmd_ctrl: RTL

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

---
 rtl/reg_cmd_ctrl_pkg.sv | 18 +
 rtl/reg_cmd_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared system package: command FSM encoding and opcode defaults,
// reused by the register and ALU command paths.
package reg_cmd_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      RD_WAIT = 3'd4,
      TX_SEND = 3'd5
   } cmd_state_e;

   localparam logic [7:0] WR_CMD_DEF     = 8'hAA;
   localparam logic [7:0] RD_CMD_DEF     = 8'hBB;
   localparam int         RD_TIMEOUT_DEF = 4;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Register command controller: parses RX write/read frames, drives the
// register file and forwards read data to the TX FIFO.
module reg_cmd_ctrl
   import reg_cmd_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] WR_CMD     = WR_CMD_DEF,
   parameter logic [DATA_WIDTH-1:0] RD_CMD     = RD_CMD_DEF,
   parameter int                    RD_TIMEOUT = RD_TIMEOUT_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_Valid,
   input  logic                  FIFO_FULL,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [DATA_WIDTH-1:0] WrData,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   output logic                  CMD_ERR
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

   cmd_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic                  tx_vld_q, tx_vld_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  addr_ok;

   // Address bytes must not set any bit above the register-file range.
   assign addr_ok = (RX_P_DATA >> ADDR_WIDTH) == '0;

   always_comb begin
      state_d    = state_q;
      addr_lat_d = addr_lat_q;
      address_d  = address_q;
      wr_data_d  = wr_data_q;
      tx_data_d  = tx_data_q;
      cnt_d      = cnt_q;
      wr_en_d    = 1'b0;
      rd_en_d    = 1'b0;
      tx_vld_d   = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == WR_CMD) begin
                  state_d = WR_ADDR;
               end else if (RX_P_DATA == RD_CMD) begin
                  state_d = RD_ADDR;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               if (!addr_ok) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  addr_lat_d = RX_P_DATA[ADDR_WIDTH-1:0];
                  state_d    = WR_DATA;
               end
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               wr_data_d = RX_P_DATA;
               address_d = addr_lat_q;
               state_d   = IDLE;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               if (!addr_ok) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                  rd_en_d   = 1'b1;
                  cnt_d     = '0;
                  state_d   = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (RX_D_VLD) err_d = 1'b1;
            if (RdData_Valid) begin
               tx_data_d = RdData;
               state_d   = TX_SEND;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX_SEND: begin
            if (RX_D_VLD) err_d = 1'b1;
            if (!FIFO_FULL) begin
               tx_vld_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         addr_lat_q <= '0;
         address_q  <= '0;
         wr_data_q  <= '0;
         tx_data_q  <= '0;
         cnt_q      <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         tx_vld_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_lat_q <= addr_lat_d;
         address_q  <= address_d;
         wr_data_q  <= wr_data_d;
         tx_data_q  <= tx_data_d;
         cnt_q      <= cnt_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         tx_vld_q   <= tx_vld_d;
         err_q      <= err_d;
      end
   end

   assign Address   = address_q;
   assign WrEn      = wr_en_q;
   assign RdEn      = rd_en_q;
   assign WrData    = wr_data_q;
   assign TX_P_DATA = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign CMD_ERR   = err_q;

endmodule
